// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 line receivers: FSM states, line levels, vote helper.
// Latency: none (declarations only).
// Backpressure: not applicable.
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Majority of three samples; a single-cycle disturbance cannot flip the result.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_sync2.sv
// Two-flop synchroniser for an asynchronous serial line input.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; resets to the idle line level so no edge is seen on release.
module rs232_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  import rs232_pkg::*;

  logic meta;

  // Resolve metastability on the first flop, present a clean level on the second.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= IDLE_LVL;
      q    <= IDLE_LVL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs232_rx_oversampler.sv
// Oversampling 8N1 receiver with 3-point mid-bit majority vote and a one-entry output register.
// Latency: byte valid 9*CLKS_PER_BIT+MID+2 cycles after the start edge is detected.
// Backpressure: rx_valid/rx_ready; a byte completing while the register is held is dropped with overrun.
module rs232_rx_oversampler #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = rs232_pkg::DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  import rs232_pkg::*;

  // CLKS_PER_BIT must be at least 4 so the three sample points fit inside one bit.
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] SMP_A    = CW'(MID - 1);
  localparam logic [CW-1:0] SMP_B    = CW'(MID);
  localparam logic [CW-1:0] SMP_VOTE = CW'(MID + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  state_t                 state;
  logic                   sync;
  logic                   prev;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   smp_a;
  logic                   smp_b;
  logic [DATA_BITS-1:0]   shreg;
  logic                   vote;
  logic                   at_vote;

  rs232_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (sync)
  );

  // Third sample is the live synchronised level at the vote point.
  assign vote    = maj3(smp_a, smp_b, sync);
  assign at_vote = (cnt == SMP_VOTE);

  // Frame FSM, bit timing, sampling and the output holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prev      <= IDLE_LVL;
      cnt       <= '0;
      idx       <= '0;
      smp_a     <= 1'b0;
      smp_b     <= 1'b0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      prev      <= sync;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Bit timer free-runs across bit boundaries once a frame is in progress.
      if (state != IDLE) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end

      if (cnt == SMP_A) smp_a <= sync;
      if (cnt == SMP_B) smp_b <= sync;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (prev == IDLE_LVL && sync == START_LVL) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (at_vote) begin
            if (vote == START_LVL) begin
              state <= DATA;
              idx   <= '0;
            end else begin
              // Glitch shorter than half a bit: quietly abandon.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        DATA: begin
          if (at_vote) begin
            shreg[idx] <= vote;
            idx        <= idx + 1'b1;
            if (idx == IDX_LAST) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          if (at_vote) begin
            if (vote == STOP_LVL) begin
              // Leave at mid stop bit so a start bit right behind it is caught.
              state <= IDLE;
              busy  <= 1'b0;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end

        BREAK: begin
          // Hold off until the line returns high so a long low gives one error.
          if (sync == IDLE_LVL) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs232_rx_oversampler.sv
// Directed self-checking bench for the oversampling receiver at default timing.
// Inputs are driven 1 time unit after the rising edge, outputs are observed on the falling edge.
// Each scenario task compares the monitored activity against hand-computed expectations.
module tb_rs232_rx_oversampler;

  localparam int CPB = 16;
  // Cycles from driving the start bit low to rx_valid/flag visibility: 3 detect + 154.
  localparam int LAT = 157;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int n_rise = 0, rise_cyc = 0, n_vhi = 0;
  int n_ferr = 0, ferr_cyc = 0;
  int n_ovr = 0, ovr_cyc = 0;
  int busy_start = 0, busy_len = 0;
  logic last_valid = 1'b0, last_busy = 1'b0;
  logic [7:0] xfer_q[$];

  rs232_rx_oversampler #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  // Passive monitor of the output side.
  always @(negedge clk) begin
    if (rx_valid && !last_valid) begin
      n_rise   = n_rise + 1;
      rise_cyc = cyc;
    end
    if (rx_valid) n_vhi = n_vhi + 1;
    if (rx_valid && rx_ready) xfer_q.push_back(rx_data);
    if (frame_err) begin
      n_ferr   = n_ferr + 1;
      ferr_cyc = cyc;
    end
    if (overrun) begin
      n_ovr   = n_ovr + 1;
      ovr_cyc = cyc;
    end
    if (busy && !last_busy) busy_start = cyc;
    if (!busy && last_busy) busy_len = cyc - busy_start;
    last_valid = rx_valid;
    last_busy  = busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // spike_pos: frame bit position (0=start) that carries a 1-cycle inverted spike at mid-bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int spike_pos);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int p = 0; p < 10; p++) begin
      rx_in = f[p];
      if (p == spike_pos) begin
        tick(9);
        rx_in = ~f[p];
        tick(1);
        rx_in = f[p];
        tick(6);
      end else begin
        tick(CPB);
      end
    end
    rx_in = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    tick(3);
    rst = 1'b0;
    tick(8);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL release_busy got=%b want=0", busy); end
    total++; if (n_rise !== 0) begin bad++; $display("FAIL release_valid_rises got=%0d want=0", n_rise); end
  endtask

  task automatic test_basic();
    int r0, v0, f0, o0, q0, start;
    rx_ready = 1'b1;
    r0 = n_rise; v0 = n_vhi; f0 = n_ferr; o0 = n_ovr; q0 = xfer_q.size();
    start = cyc;
    send_frame(8'hA5, 1'b1, -1);
    tick(20);
    total++; if (n_rise - r0 !== 1) begin bad++; $display("FAIL a5_rises got=%0d want=1", n_rise - r0); end
    total++; if (rise_cyc - start !== LAT) begin bad++; $display("FAIL a5_latency got=%0d want=%0d", rise_cyc - start, LAT); end
    total++; if (n_vhi - v0 !== 1) begin bad++; $display("FAIL a5_valid_width got=%0d want=1", n_vhi - v0); end
    total++; if (xfer_q.size() - q0 !== 1) begin bad++; $display("FAIL a5_xfers got=%0d want=1", xfer_q.size() - q0); end
    else begin
      total++; if (xfer_q[q0] !== 8'hA5) begin bad++; $display("FAIL a5_data got=%h want=a5", xfer_q[q0]); end
    end
    total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL a5_frame_err got=%0d want=0", n_ferr - f0); end
    total++; if (n_ovr - o0 !== 0) begin bad++; $display("FAIL a5_overrun got=%0d want=0", n_ovr - o0); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL a5_data_hold got=%h want=a5", rx_data); end
  endtask

  task automatic test_glitch();
    int r0, f0, o0;
    r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    busy_len = 0;
    rx_in = 1'b0;
    tick(5);
    rx_in = 1'b1;
    tick(30);
    total++; if (busy_len !== CPB / 2 + 2) begin bad++; $display("FAIL glitch_busy_len got=%0d want=%0d", busy_len, CPB / 2 + 2); end
    total++; if (n_rise - r0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", n_rise - r0); end
    total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL glitch_frame_err got=%0d want=0", n_ferr - f0); end
    total++; if (n_ovr - o0 !== 0) begin bad++; $display("FAIL glitch_overrun got=%0d want=0", n_ovr - o0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b want=0", busy); end
  endtask

  task automatic test_frame_err();
    int r0, f0, q0, start;
    r0 = n_rise; f0 = n_ferr;
    start = cyc;
    send_frame(8'h3C, 1'b0, -1);
    rx_in = 1'b0;
    tick(40);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_in_break got=%b want=1", busy); end
    rx_in = 1'b1;
    tick(30);
    total++; if (n_ferr - f0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d want=1", n_ferr - f0); end
    total++; if (ferr_cyc - start !== LAT) begin bad++; $display("FAIL ferr_timing got=%0d want=%0d", ferr_cyc - start, LAT); end
    total++; if (n_rise - r0 !== 0) begin bad++; $display("FAIL ferr_valid got=%0d want=0", n_rise - r0); end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL ferr_data_kept got=%h want=a5", rx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_break_exit got=%b want=0", busy); end
    q0 = xfer_q.size();
    send_frame(8'h55, 1'b1, -1);
    tick(20);
    total++; if (xfer_q.size() - q0 !== 1) begin bad++; $display("FAIL after_ferr_xfers got=%0d want=1", xfer_q.size() - q0); end
    else begin
      total++; if (xfer_q[q0] !== 8'h55) begin bad++; $display("FAIL after_ferr_data got=%h want=55", xfer_q[q0]); end
    end
  endtask

  task automatic test_back_to_back();
    int r0, o0, q0, start2;
    rx_ready = 1'b0;
    r0 = n_rise; o0 = n_ovr; q0 = xfer_q.size();
    send_frame(8'h11, 1'b1, -1);
    start2 = cyc;
    send_frame(8'h22, 1'b1, -1);
    tick(20);
    total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", rx_valid); end
    total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL b2b_data got=%h want=11", rx_data); end
    total++; if (n_ovr - o0 !== 1) begin bad++; $display("FAIL b2b_overrun_count got=%0d want=1", n_ovr - o0); end
    total++; if (ovr_cyc - start2 !== LAT) begin bad++; $display("FAIL b2b_overrun_timing got=%0d want=%0d", ovr_cyc - start2, LAT); end
    total++; if (n_rise - r0 !== 1) begin bad++; $display("FAIL b2b_rises got=%0d want=1", n_rise - r0); end
    rx_ready = 1'b1;
    tick(1);
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain_valid got=%b want=0", rx_valid); end
    total++; if (xfer_q.size() - q0 !== 1) begin bad++; $display("FAIL b2b_xfers got=%0d want=1", xfer_q.size() - q0); end
    else begin
      total++; if (xfer_q[q0] !== 8'h11) begin bad++; $display("FAIL b2b_xfer_data got=%h want=11", xfer_q[q0]); end
    end
    tick(3);
    total++; if (rx_data !== 8'h11) begin bad++; $display("FAIL b2b_data_hold got=%h want=11", rx_data); end
  endtask

  task automatic test_spike();
    int f0, q0;
    rx_ready = 1'b1;
    f0 = n_ferr; q0 = xfer_q.size();
    // Data bit 3 sits at frame position 4.
    send_frame(8'h81, 1'b1, 4);
    tick(20);
    total++; if (xfer_q.size() - q0 !== 1) begin bad++; $display("FAIL spike_xfers got=%0d want=1", xfer_q.size() - q0); end
    else begin
      total++; if (xfer_q[q0] !== 8'h81) begin bad++; $display("FAIL spike_data got=%h want=81", xfer_q[q0]); end
    end
    total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL spike_frame_err got=%0d want=0", n_ferr - f0); end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] f;
    int r0, f0, q0;
    f = {1'b1, 8'hFF, 1'b0};
    for (int p = 0; p < 5; p++) begin
      rx_in = f[p];
      tick(CPB);
    end
    rx_in = f[5];
    tick(8);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrst_busy_before got=%b want=1", busy); end
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx_data got=%h want=00", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL midrst_rx_valid got=%b want=0", rx_valid); end
    total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b%b want=00", frame_err, overrun); end
    tick(2);
    rst = 1'b0;
    r0 = n_rise; f0 = n_ferr;
    tick(6 + 4 * CPB + 20);
    total++; if (n_rise - r0 !== 0) begin bad++; $display("FAIL midrst_tail_valid got=%0d want=0", n_rise - r0); end
    total++; if (n_ferr - f0 !== 0) begin bad++; $display("FAIL midrst_tail_frame_err got=%0d want=0", n_ferr - f0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_tail_busy got=%b want=0", busy); end
    q0 = xfer_q.size();
    send_frame(8'h5A, 1'b1, -1);
    tick(20);
    total++; if (xfer_q.size() - q0 !== 1) begin bad++; $display("FAIL midrst_next_xfers got=%0d want=1", xfer_q.size() - q0); end
    else begin
      total++; if (xfer_q[q0] !== 8'h5A) begin bad++; $display("FAIL midrst_next_data got=%h want=5a", xfer_q[q0]); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_in    = 1'b1;
    rx_ready = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_spike();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
